// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and control-vector type for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int REG_W      = 3;
    localparam int HALT_DRAIN = 3;
    localparam int CNT_W      = 16;

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_DMEM_WAIT = 3'd1;
    localparam logic [2:0] ST_IMEM_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN     = 3'd3;
    localparam logic [2:0] ST_HALTED    = 3'd4;

    typedef enum logic [2:0] {
        RUN       = ST_RUN,
        DMEM_WAIT = ST_DMEM_WAIT,
        IMEM_WAIT = ST_IMEM_WAIT,
        DRAIN     = ST_DRAIN,
        HALTED    = ST_HALTED
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_bubble;
    } ctrl_t;

    // Canned enable/clear patterns; field order follows ctrl_t.
    localparam ctrl_t CTRL_GO     = 8'b1101_0110;
    localparam ctrl_t CTRL_RST    = 8'b0010_1001;
    localparam ctrl_t CTRL_DSTALL = 8'b0000_0001;
    localparam ctrl_t CTRL_DHOLD  = 8'b0010_0001;
    localparam ctrl_t CTRL_BR     = 8'b1111_1110;
    localparam ctrl_t CTRL_LU     = 8'b0001_1110;
    localparam ctrl_t CTRL_FETCH  = 8'b0111_0110;
    localparam ctrl_t CTRL_STOP   = 8'b0000_0000;

endpackage

// File: rtl/ld_use_cmp.sv
// Load-use hazard detect: a load in ID/EX whose destination is read by the instruction in IF/ID.
module ld_use_cmp #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic             mem_en,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic             rs_vld,
    input  logic [REG_W-1:0] rt,
    input  logic             rt_vld,
    output logic             lu
);

    logic [1:0][REG_W-1:0] src;
    logic [1:0]            src_vld;
    logic [1:0]            hit;

    assign src     = {rt, rs};
    assign src_vld = {rt_vld, rs_vld};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit[gi] = src_vld[gi] & (src[gi] == rd);
        end
    endgenerate

    assign lu = mem_en & ~mem_wr & (|hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges hazard, redirect and memory stalls into stage enables and sequences HALT.
// Optional saturating perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int REG_W      = pipe_ctrl_pkg::REG_W,
    parameter int HALT_DRAIN = pipe_ctrl_pkg::HALT_DRAIN,
    parameter int CNT_W      = pipe_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_mem_en,
    input  logic             id_ex_mem_wr,
    input  logic [REG_W-1:0] id_ex_Rd,
    input  logic [REG_W-1:0] if_id_Rs,
    input  logic             if_id_Rs_vld,
    input  logic [REG_W-1:0] if_id_Rt,
    input  logic             if_id_Rt_vld,
    input  logic             ex_br_taken,
    input  logic             halt_id,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);
    import pipe_ctrl_pkg::*;

    localparam int DRAIN_W = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);

    state_t             state_reg, state_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic               fetch_ok_reg, fetch_ok_next;
    logic               halted_reg;
    logic               lu;
    ctrl_t              ctrl;

    ld_use_cmp #(.REG_W(REG_W)) u_ld_use_cmp (
        .mem_en (id_ex_mem_en),
        .mem_wr (id_ex_mem_wr),
        .rd     (id_ex_Rd),
        .rs     (if_id_Rs),
        .rs_vld (if_id_Rs_vld),
        .rt     (if_id_Rt),
        .rt_vld (if_id_Rt_vld),
        .lu     (lu)
    );

    always_comb begin
        ctrl           = CTRL_GO;
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            RUN, IMEM_WAIT: begin
                if (dmem_stall) begin
                    ctrl       = CTRL_DSTALL;
                    state_next = DMEM_WAIT;
                end else if (ex_br_taken) begin
                    ctrl       = CTRL_BR;
                    state_next = RUN;
                end else if (lu) begin
                    ctrl = CTRL_LU;
                end else if (state_reg == IMEM_WAIT) begin
                    if (imem_done | fetch_ok_reg)
                        state_next = RUN;
                    else
                        ctrl = CTRL_FETCH;
                end else if (halt_id) begin
                    ctrl           = CTRL_FETCH;
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_W'(HALT_DRAIN);
                end else if (imem_stall) begin
                    ctrl       = CTRL_FETCH;
                    state_next = IMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                // The done cycle releases everything so MEM/WB captures the load result.
                if (dmem_done)
                    state_next = (fetch_ok_reg | ~imem_stall) ? RUN : IMEM_WAIT;
                else
                    ctrl = CTRL_DSTALL;
            end
            DRAIN: begin
                if (dmem_stall) begin
                    ctrl = CTRL_DHOLD;
                end else begin
                    ctrl           = CTRL_FETCH;
                    drain_cnt_next = (drain_cnt_reg != '0) ? drain_cnt_reg - 1'b1 : '0;
                    if (drain_cnt_reg <= DRAIN_W'(1))
                        state_next = HALTED;
                end
            end
            HALTED:  ctrl = CTRL_STOP;
            default: state_next = RUN;
        endcase
        if (rst)
            ctrl = CTRL_RST;
    end

    // A fetch that completes while IF/ID is frozen is remembered until IF/ID loads.
    always_comb begin
        fetch_ok_next = fetch_ok_reg;
        if (ctrl.if_id_en)
            fetch_ok_next = 1'b0;
        else if (imem_done && (state_reg == DMEM_WAIT || state_reg == IMEM_WAIT))
            fetch_ok_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            drain_cnt_reg <= '0;
            fetch_ok_reg  <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            fetch_ok_reg  <= fetch_ok_next;
            halted_reg    <= (state_next == HALTED);
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_en      = ctrl.id_ex_en;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign halted        = halted_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             br_apply;

    // Only redirects that actually take effect are counted, not cycles a branch sits behind a stall.
    assign br_apply = ex_br_taken & ~dmem_stall & (state_reg == RUN || state_reg == IMEM_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (~ctrl.pc_en && state_reg != HALTED && ~&stall_cnt_reg)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (br_apply && ~&flush_cnt_reg)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_flush_cnt = flush_cnt_reg;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a mode-flag reference model.
module tb_pipe_ctrl;

    localparam int RW  = 3;
    localparam int HD  = 3;
    localparam int CW  = 16;
    localparam int CMAX = (1 << CW) - 1;

    // Expected vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, mem_wb_bubble
    localparam logic [7:0] V_GO     = 8'b1101_0110;
    localparam logic [7:0] V_RST    = 8'b0010_1001;
    localparam logic [7:0] V_DSTALL = 8'b0000_0001;
    localparam logic [7:0] V_DHOLD  = 8'b0010_0001;
    localparam logic [7:0] V_BR     = 8'b1111_1110;
    localparam logic [7:0] V_LU     = 8'b0001_1110;
    localparam logic [7:0] V_FETCH  = 8'b0111_0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_ex_mem_en, id_ex_mem_wr, if_id_Rs_vld, if_id_Rt_vld;
    logic [RW-1:0] id_ex_Rd, if_id_Rs, if_id_Rt;
    logic          ex_br_taken, halt_id, imem_stall, imem_done, dmem_stall, dmem_done;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic          ex_mem_en, mem_wb_en, mem_wb_bubble, halted;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_ex_mem_en(id_ex_mem_en), .id_ex_mem_wr(id_ex_mem_wr), .id_ex_Rd(id_ex_Rd),
        .if_id_Rs(if_id_Rs), .if_id_Rs_vld(if_id_Rs_vld),
        .if_id_Rt(if_id_Rt), .if_id_Rt_vld(if_id_Rt_vld),
        .ex_br_taken(ex_br_taken), .halt_id(halt_id),
        .imem_stall(imem_stall), .imem_done(imem_done),
        .dmem_stall(dmem_stall), .dmem_done(dmem_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: which kind of wait the pipe is in, drain cycles left, pending fetch.
    bit m_halted, m_drain, m_dwait, m_iwait, m_fok;
    int m_left, m_stalls, m_flushes;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; id_ex_mem_en = 1'b0; id_ex_mem_wr = 1'b0; id_ex_Rd = '0;
        if_id_Rs = '0; if_id_Rs_vld = 1'b0; if_id_Rt = '0; if_id_Rt_vld = 1'b0;
        ex_br_taken = 1'b0; halt_id = 1'b0; imem_stall = 1'b0; imem_done = 1'b0;
        dmem_stall = 1'b0; dmem_done = 1'b0;
    endtask

    // Compare outputs against the model at the falling edge, then advance the model.
    task automatic tick();
        logic [7:0] exp_vec, got_vec;
        bit lu, waiting, fok_old, redirect;
        @(negedge clk);
        lu = id_ex_mem_en && !id_ex_mem_wr &&
             ((if_id_Rs_vld && if_id_Rs == id_ex_Rd) || (if_id_Rt_vld && if_id_Rt == id_ex_Rd));
        waiting = m_dwait || m_iwait;
        fok_old = m_fok;
        exp_vec = V_GO;
        if (rst)                            exp_vec = V_RST;
        else if (m_halted)                  exp_vec = 8'h00;
        else if (m_drain)                   exp_vec = dmem_stall ? V_DHOLD : V_FETCH;
        else if (m_dwait)                   exp_vec = dmem_done ? V_GO : V_DSTALL;
        else if (dmem_stall)                exp_vec = V_DSTALL;
        else if (ex_br_taken)               exp_vec = V_BR;
        else if (lu)                        exp_vec = V_LU;
        else if (m_iwait)                   exp_vec = (imem_done || m_fok) ? V_GO : V_FETCH;
        else if (halt_id || imem_stall)     exp_vec = V_FETCH;
        got_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, mem_wb_bubble};
        check_val("ctrl", 32'(got_vec), 32'(exp_vec));
        check_val("halted", 32'(halted), 32'(m_halted));
`ifdef PIPE_CTRL_PERF_EN
        check_val("perf_stall", 32'(perf_stall_cnt), 32'(m_stalls));
        check_val("perf_flush", 32'(perf_flush_cnt), 32'(m_flushes));
`else
        check_val("perf_stall", 32'(perf_stall_cnt), 32'd0);
        check_val("perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
        if (rst) begin
            m_halted = 0; m_drain = 0; m_dwait = 0; m_iwait = 0; m_fok = 0;
            m_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            redirect = !m_halted && !m_drain && !m_dwait && !dmem_stall && ex_br_taken;
            if (!exp_vec[7] && !m_halted && m_stalls < CMAX) m_stalls++;
            if (redirect && m_flushes < CMAX) m_flushes++;
            if (exp_vec[6]) m_fok = 0;
            else if (waiting && imem_done) m_fok = 1;
            if (m_halted) begin
            end else if (m_drain) begin
                if (!dmem_stall) begin
                    if (m_left > 0) m_left--;
                    if (m_left == 0) begin m_drain = 0; m_halted = 1; end
                end
            end else if (m_dwait) begin
                if (dmem_done) begin
                    m_dwait = 0;
                    m_iwait = !(fok_old || !imem_stall);
                end
            end else if (dmem_stall) begin
                m_dwait = 1; m_iwait = 0;
            end else if (ex_br_taken) begin
                m_iwait = 0;
            end else if (lu) begin
            end else if (m_iwait) begin
                if (imem_done || fok_old) m_iwait = 0;
            end else if (halt_id) begin
                m_drain = 1; m_left = HD;
            end else if (imem_stall) begin
                m_iwait = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        int halt_cyc, seen;
        idle();
        rst = 1'b1;
        m_halted = 0; m_drain = 0; m_dwait = 0; m_iwait = 0; m_fok = 0;
        m_left = 0; m_stalls = 0; m_flushes = 0;
        tick(); tick();
        rst = 1'b0;
        $display("reset: checks=%0d", checks);

        // Load-use on Rs, then clear when the load moves on; Rs_vld=0 never stalls.
        id_ex_mem_en = 1; id_ex_Rd = 3'd3; if_id_Rs = 3'd3; if_id_Rs_vld = 1;
        tick();
        id_ex_mem_en = 0; tick();
        id_ex_mem_en = 1; if_id_Rs_vld = 0; tick();
        if_id_Rt = 3'd3; if_id_Rt_vld = 1; id_ex_mem_wr = 1; tick();
        idle(); tick();
        $display("load_use: checks=%0d", checks);

        // Branch beats load-use.
        id_ex_mem_en = 1; id_ex_Rd = 3'd5; if_id_Rt = 3'd5; if_id_Rt_vld = 1; ex_br_taken = 1;
        tick();
        idle(); tick();
        $display("branch_over_lu: checks=%0d", checks);

        // Four stalled cycles, release on the fifth.
        dmem_stall = 1;
        repeat (4) tick();
        dmem_done = 1; tick();
        idle(); tick();
        $display("dmem_stall: checks=%0d", checks);

        // Fetch completes while the data side is stalled: no return to fetch wait.
        imem_stall = 1; tick();
        dmem_stall = 1; tick();
        imem_done = 1; tick();
        imem_done = 0; tick();
        dmem_done = 1; tick();
        dmem_stall = 0; dmem_done = 0; imem_stall = 0; tick();
        idle(); tick();
        $display("fetch_ok: checks=%0d", checks);

        // HALT with a two-cycle data stall inside the drain.
        halt_id = 1; halt_cyc = cyc; tick();
        halt_id = 0; dmem_stall = 1; tick(); tick();
        dmem_stall = 0;
        seen = -1;
        for (int i = 0; i < 30 && seen < 0; i++) begin
            if (halted === 1'b1) seen = cyc;
            tick();
        end
        check_val("halt_latency", 32'(seen - halt_cyc), 32'd6);
        repeat (2) tick();
        do_reset();
        tick();
        check_val("halt_cleared", 32'(halted), 32'd0);
        $display("halt_drain: checks=%0d", checks);

        // HALT on the wrong path of a taken branch is cancelled.
        halt_id = 1; ex_br_taken = 1; tick();
        idle();
        repeat (8) tick();
        check_val("halt_cancel", 32'(halted), 32'd0);
        $display("halt_cancel: checks=%0d", checks);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(0, 99) < 1) || (m_halted && $urandom_range(0, 3) == 0);
            dmem_stall   = $urandom_range(0, 99) < 15;
            dmem_done    = $urandom_range(0, 99) < 40;
            imem_stall   = $urandom_range(0, 99) < 20;
            imem_done    = $urandom_range(0, 99) < 40;
            ex_br_taken  = $urandom_range(0, 99) < 10;
            halt_id      = $urandom_range(0, 99) < 3;
            id_ex_mem_en = $urandom_range(0, 99) < 40;
            id_ex_mem_wr = $urandom_range(0, 3) == 0;
            id_ex_Rd     = RW'($urandom);
            if_id_Rs     = RW'($urandom);
            if_id_Rt     = RW'($urandom);
            if_id_Rs_vld = $urandom_range(0, 1) == 1;
            if_id_Rt_vld = $urandom_range(0, 1) == 1;
            tick();
            if (n % 250 == 249) $display("random batch %0d: checks=%0d", n / 250, checks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage 16-bit processor. It combines four sources into one set of per-stage register enables, bubbles and flushes:
- load-use hazard
- EX-resolved branch/jump redirect
- multicycle instruction memory stall
- multicycle data memory stall
It also sequences HALT: drain the pipe, then stop. It sits beside the pipeline registers and drives their enable and clear inputs.

Parameters:
REG_W, 3, register specifier width
HALT_DRAIN, 3, cycles after HALT leaves ID before halted asserts
CNT_W, 16, perf counter width (used only with feature)

Ports:
clk in 1 system clock
rst in 1 synchronous active-high reset
id_ex_mem_en in 1 instr in ID/EX accesses data mem
id_ex_mem_wr in 1 that access is a store
id_ex_Rd in REG_W destination of instr in ID/EX
if_id_Rs in REG_W source 1 of instr in IF/ID
if_id_Rs_vld in 1 instr actually reads Rs
if_id_Rt in REG_W source 2 of instr in IF/ID
if_id_Rt_vld in 1 instr actually reads Rt
ex_br_taken in 1 EX redirects PC this cycle
halt_id in 1 HALT decoded in ID
imem_stall in 1 instr mem busy
imem_done in 1 instr mem data valid
dmem_stall in 1 data mem busy
dmem_done in 1 data mem access complete
pc_en out 1 PC update enable
if_id_en out 1 IF/ID load enable
if_id_flush out 1 IF/ID loads NOP
id_ex_en out 1 ID/EX load enable
id_ex_bubble out 1 ID/EX loads NOP
ex_mem_en out 1 EX/MEM load enable
mem_wb_en out 1 MEM/WB load enable
mem_wb_bubble out 1 MEM/WB loads NOP
halted out 1 registered; core stopped
perf_stall_cnt out CNT_W stall-cycle count
perf_flush_cnt out CNT_W redirect count

Behaviour:
- Load-use hazard: lu = id_ex_mem_en & ~id_ex_mem_wr & ((if_id_Rs_vld & Rs==Rd) | (if_id_Rt_vld & Rt==Rd)).
- FSM states: RUN, DMEM_WAIT, IMEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and inputs. halted is registered.
- Reset: state=RUN, drain_cnt=0, fetch_ok=0, halted=0, perf counters=0. While rst is high, all *_en=0, all flush/bubble=1.
- RUN, nothing active: all en=1, flush/bubble=0.
- Priority, highest first: dmem, branch, load-use, imem.
- dmem_stall in RUN or IMEM_WAIT: pc/if_id/id_ex/ex_mem en=0; mem_wb_bubble=1; next state DMEM_WAIT.
- DMEM_WAIT: hold as above until dmem_done.
  - On the dmem_done cycle, all en=1 (MEM/WB captures the result).
  - Next state is RUN if fetch_ok or no imem_stall; otherwise IMEM_WAIT.
  - imem_done seen during DMEM_WAIT sets fetch_ok. fetch_ok clears when if_id_en=1.
- ex_br_taken (no dmem stall): if_id_flush=1, id_ex_bubble=1, pc_en=1. This overrides lu and imem stall. fetch_ok clears. Counts as one flush.
- lu (no dmem/branch): pc_en=0, if_id_en=0, id_ex_bubble=1, downstream en=1. Lasts exactly 1 cycle because the load moves to EX/MEM.
- imem_stall in RUN: pc_en=0, if_id_flush=1, downstream advance; next state IMEM_WAIT. Stay there until imem_done. On the done cycle, pc_en=1, if_id_en=1, flush=0, then RUN.
- halt_id in RUN with no branch/lu: pc_en=0 and if_id_flush=1 thereafter; next state DRAIN, drain_cnt=HALT_DRAIN.
  - DRAIN decrements drain_cnt only on cycles where mem_wb_en=1. A dmem stall inside DRAIN holds the count.
  - At 0, go to HALTED and halted=1 on the next edge.
  - A branch simultaneous with halt_id cancels the halt (wrong path).
- HALTED: all en=0; sticky until rst.
- Reset asserted mid-wait or mid-drain returns to RUN the next edge; pending fetch_ok is discarded.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: perf_stall_cnt increments each cycle pc_en=0 and state≠HALTED. perf_flush_cnt increments per ex_br_taken. Both saturate at all-ones and clear on rst.
- Undefined: both outputs tied to 0; no counter flops.

Decomposition:
- pipe_ctrl_pkg holds the state encoding localparams (3-bit), REG_W, HALT_DRAIN default, and CNT_W.
- One combinational sub-module, ld_use_cmp, computes lu from the ID/EX and IF/ID fields with the valid qualifiers. The rest lives in pipe_ctrl.

Test Plan:
- Load R3 in ID/EX, IF/ID reads Rs=3 with vld=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1. With Rs_vld=0 -> no stall.
- ex_br_taken=1 while lu=1 -> if_id_flush=1, id_ex_bubble=1, pc_en=1, no stall; perf_flush_cnt +1.
- dmem_stall for 4 cycles, done on cycle 5 -> pc/if_id/id_ex/ex_mem en=0 and mem_wb_bubble=1 for 4 cycles; all en=1 on cycle 5; state RUN.
- imem_done during DMEM_WAIT with imem_stall still high -> fetch_ok=1; after dmem_done, state is RUN, not IMEM_WAIT.
- halt_id, then a 2-cycle dmem stall in DRAIN -> halted rises 3+2+1 cycles after halt_id; rst afterwards -> halted=0, state RUN.
- halt_id and ex_br_taken in the same cycle -> no DRAIN; PC redirects and halted stays 0.
